// File: rtl/u_sequencer_pkg.sv
// Shared constants for the ARC microsequencer: state codes, ALU codes,
// register-file indices and instruction field values.
package u_sequencer_pkg;

    localparam int unsigned DATAWIDTH_DECODER_SELECTION = 6;
    localparam int unsigned DATAWIDTH_MUX_SELECTION     = 6;
    localparam int unsigned DATAWIDTH_ALU_SELECTION     = 4;
    localparam int unsigned DATAWIDTH_STATE             = 4;

    typedef enum logic [DATAWIDTH_STATE-1:0] {
        ST_RST    = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_IMM    = 4'd3,
        ST_ALU    = 4'd4,
        ST_ADDR   = 4'd5,
        ST_LDM    = 4'd6,
        ST_STM    = 4'd7,
        ST_SETHI  = 4'd8,
        ST_BR     = 4'd9,
        ST_BRT    = 4'd10,
        ST_BRA    = 4'd11,
        ST_INCPC  = 4'd12
    } state_e;

    localparam logic [3:0] ALU_ANDCC      = 4'b0000;
    localparam logic [3:0] ALU_ORCC       = 4'b0001;
    localparam logic [3:0] ALU_ORNCC      = 4'b0010;
    localparam logic [3:0] ALU_ADDCC      = 4'b0011;
    localparam logic [3:0] ALU_SRL        = 4'b0100;
    localparam logic [3:0] ALU_ADD        = 4'b1000;
    localparam logic [3:0] ALU_LSHIFT10   = 4'b1010;
    localparam logic [3:0] ALU_SEXT13     = 4'b1100;
    localparam logic [3:0] ALU_INCPC      = 4'b1110;
    localparam logic [3:0] ALU_SEXT22SHL2 = 4'b1111;

    localparam logic [5:0] REG_PC   = 6'd32;
    localparam logic [5:0] REG_R33  = 6'd33;
    localparam logic [5:0] REG_R34  = 6'd34;
    localparam logic [5:0] REG_R35  = 6'd35;
    localparam logic [5:0] REG_R36  = 6'd36;
    localparam logic [5:0] REG_IR   = 6'd37;
    localparam logic [5:0] REG_NONE = 6'd63;

    localparam logic [1:0] OP_BRANCH = 2'b00;
    localparam logic [1:0] OP_ARITH  = 2'b10;
    localparam logic [1:0] OP_MEM    = 2'b11;

    localparam logic [2:0] OP2_BICC  = 3'b010;
    localparam logic [2:0] OP2_SETHI = 3'b100;

    localparam logic [5:0] OP3_ADDCC = 6'b010000;
    localparam logic [5:0] OP3_ANDCC = 6'b010001;
    localparam logic [5:0] OP3_ORCC  = 6'b010010;
    localparam logic [5:0] OP3_ORNCC = 6'b010110;
    localparam logic [5:0] OP3_SRL   = 6'b100110;
    localparam logic [5:0] OP3_LD    = 6'b000000;
    localparam logic [5:0] OP3_ST    = 6'b000100;

    localparam logic [3:0] COND_BE   = 4'b0001;
    localparam logic [3:0] COND_BCS  = 4'b0101;
    localparam logic [3:0] COND_BNEG = 4'b0110;
    localparam logic [3:0] COND_BVS  = 4'b0111;
    localparam logic [3:0] COND_BA   = 4'b1000;

    // ALU operation for a supported arithmetic op3.
    function automatic logic [3:0] alu_of_op3(input logic [5:0] op3);
        case (op3)
            OP3_ADDCC: return ALU_ADDCC;
            OP3_ORCC:  return ALU_ORCC;
            OP3_ORNCC: return ALU_ORNCC;
            OP3_SRL:   return ALU_SRL;
            default:   return ALU_ANDCC;
        endcase
    endfunction

    function automatic logic is_arith_op3(input logic [5:0] op3);
        return (op3 == OP3_ADDCC) || (op3 == OP3_ANDCC) || (op3 == OP3_ORCC) ||
               (op3 == OP3_ORNCC) || (op3 == OP3_SRL);
    endfunction

    function automatic logic is_mem_op3(input logic [5:0] op3);
        return (op3 == OP3_LD) || (op3 == OP3_ST);
    endfunction

endpackage

// File: rtl/u_sequencer_branch_eval.sv
// Bicc condition evaluator: decides whether a branch is taken from the latched flags.
module u_sequencer_branch_eval
    import u_sequencer_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic       n_i,
    input  logic       z_i,
    input  logic       v_i,
    input  logic       c_i,
    output logic       taken_o
);

    // Unsupported conditions are never taken.
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_BE:   taken_o = z_i;
            COND_BCS:  taken_o = c_i;
            COND_BNEG: taken_o = n_i;
            COND_BVS:  taken_o = v_i;
            COND_BA:   taken_o = 1'b1;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/u_sequencer.sv
// Microsequencer for the ARC datapath: fetch/decode/execute control with
// Moore outputs decoded from the state register and the IR fields.
module u_sequencer
    import u_sequencer_pkg::*;
(
    input  logic                                   u_sequencer_CLOCK_50,
    input  logic                                   u_sequencer_Reset_InHigh,
    input  logic [1:0]                             RegIR_OP,
    input  logic [4:0]                             RegIR_RD,
    input  logic [2:0]                             RegIR_OP2,
    input  logic [5:0]                             RegIR_OP3,
    input  logic [4:0]                             RegIR_RS1,
    input  logic                                   RegIR_BIT13,
    input  logic [4:0]                             RegIR_RS2,
    input  logic                                   PSR_Negative_In,
    input  logic                                   PSR_Zero_In,
    input  logic                                   PSR_Overflow_In,
    input  logic                                   PSR_Carry_In,
    input  logic                                   Mem_Ack_In,
    output logic [DATAWIDTH_DECODER_SELECTION-1:0] Decoder_Selection_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_SelectionBUSA_Out,
    output logic [DATAWIDTH_MUX_SELECTION-1:0]     MUX_SelectionBUSB_Out,
    output logic [DATAWIDTH_ALU_SELECTION-1:0]     ALU_Selection_Out,
    output logic                                   CBus_FromMem_Out,
    output logic                                   PSR_Load_Out,
    output logic                                   Mem_Rd_Out,
    output logic                                   Mem_Wr_Out,
    output logic                                   Illegal_Out,
    output logic [DATAWIDTH_STATE-1:0]             State_Out
);

    state_e                                 state_q;
    logic                                   br_taken;
    logic                                   arith_ok;
    logic                                   mem_ok;
    logic                                   sethi_ok;
    logic                                   bicc_ok;
    logic                                   legal;
    logic [DATAWIDTH_DECODER_SELECTION-1:0] rd_dest;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     rs1_sel;
    logic [DATAWIDTH_MUX_SELECTION-1:0]     b_sel;

    u_sequencer_branch_eval u_branch_eval (
        .cond_i  (RegIR_RD[3:0]),
        .n_i     (PSR_Negative_In),
        .z_i     (PSR_Zero_In),
        .v_i     (PSR_Overflow_In),
        .c_i     (PSR_Carry_In),
        .taken_o (br_taken)
    );

    // Instruction classification and operand selects from the IR fields.
    assign arith_ok = (RegIR_OP == OP_ARITH) && is_arith_op3(RegIR_OP3);
    assign mem_ok   = (RegIR_OP == OP_MEM) && is_mem_op3(RegIR_OP3);
    assign sethi_ok = (RegIR_OP == OP_BRANCH) && (RegIR_OP2 == OP2_SETHI);
    assign bicc_ok  = (RegIR_OP == OP_BRANCH) && (RegIR_OP2 == OP2_BICC);
    assign legal    = arith_ok || mem_ok || sethi_ok || bicc_ok;
    // r0 is hard-wired zero, so writing it means writing nothing.
    assign rd_dest  = (RegIR_RD == 5'd0) ? REG_NONE
                                         : DATAWIDTH_DECODER_SELECTION'(RegIR_RD);
    assign rs1_sel  = DATAWIDTH_MUX_SELECTION'(RegIR_RS1);
    assign b_sel    = RegIR_BIT13 ? REG_R33 : DATAWIDTH_MUX_SELECTION'(RegIR_RS2);
    assign State_Out = DATAWIDTH_STATE'(state_q);

    // State register with next-state sequencing.
    always_ff @(posedge u_sequencer_CLOCK_50 or posedge u_sequencer_Reset_InHigh) begin
        if (u_sequencer_Reset_InHigh) begin
            state_q <= ST_RST;
        end else begin
            case (state_q)
                ST_RST:    state_q <= ST_FETCH;
                ST_FETCH:  if (Mem_Ack_In) state_q <= ST_DECODE;
                ST_DECODE: begin
                    if (arith_ok)      state_q <= RegIR_BIT13 ? ST_IMM : ST_ALU;
                    else if (mem_ok)   state_q <= RegIR_BIT13 ? ST_IMM : ST_ADDR;
                    else if (sethi_ok) state_q <= ST_SETHI;
                    else if (bicc_ok)  state_q <= ST_BR;
                    else               state_q <= ST_INCPC;
                end
                ST_IMM:    state_q <= (RegIR_OP == OP_ARITH) ? ST_ALU : ST_ADDR;
                ST_ALU:    state_q <= ST_INCPC;
                ST_ADDR:   state_q <= (RegIR_OP3 == OP3_LD) ? ST_LDM : ST_STM;
                ST_LDM:    if (Mem_Ack_In) state_q <= ST_INCPC;
                ST_STM:    if (Mem_Ack_In) state_q <= ST_INCPC;
                ST_SETHI:  state_q <= ST_INCPC;
                ST_BR:     state_q <= br_taken ? ST_BRT : ST_INCPC;
                ST_BRT:    state_q <= ST_BRA;
                ST_BRA:    state_q <= ST_FETCH;
                ST_INCPC:  state_q <= ST_FETCH;
                default:   state_q <= ST_RST;
            endcase
        end
    end

    // Datapath control decode; anything not driven stays at its idle value.
    always_comb begin
        Decoder_Selection_Out = REG_NONE;
        MUX_SelectionBUSA_Out = '0;
        MUX_SelectionBUSB_Out = '0;
        ALU_Selection_Out     = ALU_ANDCC;
        CBus_FromMem_Out      = 1'b0;
        PSR_Load_Out          = 1'b0;
        Mem_Rd_Out            = 1'b0;
        Mem_Wr_Out            = 1'b0;
        Illegal_Out           = 1'b0;
        case (state_q)
            ST_FETCH: begin
                MUX_SelectionBUSA_Out = REG_PC;
                Mem_Rd_Out            = 1'b1;
                CBus_FromMem_Out      = 1'b1;
                Decoder_Selection_Out = REG_IR;
            end
            ST_DECODE: Illegal_Out = !legal;
            ST_IMM: begin
                MUX_SelectionBUSA_Out = REG_IR;
                ALU_Selection_Out     = ALU_SEXT13;
                Decoder_Selection_Out = REG_R33;
            end
            ST_ALU: begin
                MUX_SelectionBUSA_Out = rs1_sel;
                MUX_SelectionBUSB_Out = b_sel;
                Decoder_Selection_Out = rd_dest;
                ALU_Selection_Out     = alu_of_op3(RegIR_OP3);
                PSR_Load_Out          = RegIR_OP3[4];
            end
            ST_ADDR: begin
                MUX_SelectionBUSA_Out = rs1_sel;
                MUX_SelectionBUSB_Out = b_sel;
                ALU_Selection_Out     = ALU_ADD;
                Decoder_Selection_Out = REG_R34;
            end
            ST_LDM: begin
                MUX_SelectionBUSA_Out = REG_R34;
                Mem_Rd_Out            = 1'b1;
                CBus_FromMem_Out      = 1'b1;
                Decoder_Selection_Out = rd_dest;
            end
            ST_STM: begin
                MUX_SelectionBUSA_Out = REG_R34;
                MUX_SelectionBUSB_Out = DATAWIDTH_MUX_SELECTION'(RegIR_RD);
                Mem_Wr_Out            = 1'b1;
            end
            ST_SETHI: begin
                MUX_SelectionBUSA_Out = REG_IR;
                ALU_Selection_Out     = ALU_LSHIFT10;
                Decoder_Selection_Out = rd_dest;
            end
            ST_BRT: begin
                MUX_SelectionBUSA_Out = REG_IR;
                ALU_Selection_Out     = ALU_SEXT22SHL2;
                Decoder_Selection_Out = REG_R35;
            end
            ST_BRA: begin
                MUX_SelectionBUSA_Out = REG_PC;
                MUX_SelectionBUSB_Out = REG_R35;
                ALU_Selection_Out     = ALU_ADD;
                Decoder_Selection_Out = REG_PC;
            end
            ST_INCPC: begin
                MUX_SelectionBUSA_Out = REG_PC;
                ALU_Selection_Out     = ALU_INCPC;
                Decoder_Selection_Out = REG_PC;
            end
            default: ;
        endcase
    end

endmodule
